// File: rtl/register_readback_uart.sv
// register_readback_uart
// Read-reply path for the UART register interface. A request latches an
// address, reads one word from the register block, then sends the reply
// frame (response code, address, value bytes MSB-first) over an 8N1 UART.
module register_readback_uart #(
    parameter int                    WORD_WIDTH   = 8,
    parameter int                    VALUE_WORDS  = 4,
    parameter int                    DIVISOR      = 8,
    parameter int                    READ_LATENCY = 1,
    parameter logic [WORD_WIDTH-1:0] RESP_CODE    = 'h81
) (
    input  logic                              clk,
    input  logic                              i_reset,
    input  logic                              i_req,
    input  logic [WORD_WIDTH-1:0]             i_addr,
    output logic                              o_ready,
    output logic                              o_r_en,
    output logic [WORD_WIDTH-1:0]             o_r_addr,
    input  logic [WORD_WIDTH*VALUE_WORDS-1:0] i_r_value,
    output logic                              o_tx,
    output logic                              o_busy,
    output logic                              o_done
);

    localparam int NBYTES  = 2 + VALUE_WORDS;
    localparam int FRAME_W = NBYTES * WORD_WIDTH;
    localparam int DIV_W   = $clog2(DIVISOR);
    localparam int BIT_W   = $clog2(WORD_WIDTH + 2);
    localparam int BYTE_W  = $clog2(NBYTES);
    localparam int LAT_W   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIVISOR - 1);
    localparam logic [BIT_W-1:0]  BIT_STOP  = BIT_W'(WORD_WIDTH + 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NBYTES - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        LOAD = 2'd2,
        SEND = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [WORD_WIDTH-1:0]   addr_q, addr_d;
    logic                    ren_q, ren_d;
    logic                    done_q, done_d;
    logic                    tx_q, tx_d;
    logic [LAT_W-1:0]        lat_q, lat_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [BYTE_W-1:0]       byte_q, byte_d;
    // Frame is stored so that bit 0 is always the next data bit on the wire:
    // the first byte sits in the low bits and the whole vector shifts right.
    logic [FRAME_W-1:0]      frame_q, frame_d;
    logic [FRAME_W-1:0]      load_v;

    assign o_ready  = (state_q == IDLE);
    assign o_busy   = (state_q != IDLE);
    assign o_r_en   = ren_q;
    assign o_r_addr = addr_q;
    assign o_tx     = tx_q;
    assign o_done   = done_q;

    // Reorder the captured word into wire order: code, address, value MSB byte first.
    always_comb begin
        load_v = '0;
        load_v[WORD_WIDTH-1:0]            = RESP_CODE;
        load_v[2*WORD_WIDTH-1:WORD_WIDTH] = addr_q;
        for (int k = 0; k < VALUE_WORDS; k++) begin
            load_v[(2+k)*WORD_WIDTH +: WORD_WIDTH] =
                i_r_value[(VALUE_WORDS-1-k)*WORD_WIDTH +: WORD_WIDTH];
        end
    end

    // Next-state, counters and serializer; tx is registered so the pin never glitches.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ren_d   = 1'b0;
        done_d  = 1'b0;
        tx_d    = 1'b1;
        lat_d   = lat_q;
        div_d   = div_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        frame_d = frame_q;
        case (state_q)
            IDLE: begin
                if (i_req) begin
                    state_d = READ;
                    addr_d  = i_addr;
                    ren_d   = 1'b1;
                    lat_d   = '0;
                end
            end
            READ: begin
                // READ lasts READ_LATENCY cycles so data is valid during LOAD.
                if (lat_q == LAT_LAST) begin
                    state_d = LOAD;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            LOAD: begin
                frame_d = load_v;
                div_d   = '0;
                bit_d   = '0;
                byte_d  = '0;
                state_d = SEND;
            end
            SEND: begin
                if (bit_q == '0) begin
                    tx_d = 1'b0;
                end else if (bit_q == BIT_STOP) begin
                    tx_d = 1'b1;
                end else begin
                    tx_d = frame_q[0];
                end
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (bit_q == BIT_STOP) begin
                        bit_d = '0;
                        if (byte_q == BYTE_LAST) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            byte_d = byte_q + 1'b1;
                        end
                    end else begin
                        if (bit_q != '0) begin
                            frame_d = {1'b0, frame_q[FRAME_W-1:1]};
                        end
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any frame and parks tx high.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            ren_q   <= 1'b0;
            done_q  <= 1'b0;
            tx_q    <= 1'b1;
            lat_q   <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ren_q   <= ren_d;
            done_q  <= done_d;
            tx_q    <= tx_d;
            lat_q   <= lat_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            frame_q <= frame_d;
        end
    end

endmodule

// File: doc/register_readback_uart.md
Name: register_readback_uart

Overview:
- Return path for the UART register interface: on a read request, fetches one word from register_block and transmits it over a built-in 8N1 UART serializer.
- Reply frame: response code, address, then VALUE_WORDS value bytes MSB-first. Same byte order as the inbound write command (0x01, addr, value MSB-first).
- Sits between the host-side read requester (command parser read decode) and the read port of register_block; o_tx drives the board TX pin.

Parameters:
- WORD_WIDTH, 8, bits per UART byte; also the address width.
- VALUE_WORDS, 4, bytes per register value; register width = WORD_WIDTH*VALUE_WORDS.
- DIVISOR, 8, clk cycles per UART bit (integer, >= 2).
- READ_LATENCY, 1, clk cycles from o_r_en to valid i_r_value (>= 1).
- RESP_CODE, 'h81, first byte of every reply frame.

Ports:
- clk  input  1  system clock; all logic on posedge.
- i_reset  input  1  asynchronous, active-low reset.
- i_req  input  1  read request strobe; sampled only when o_ready=1.
- i_addr  input  WORD_WIDTH  register address; sampled with i_req.
- o_ready  output  1  high in IDLE only.
- o_r_en  output  1  one-cycle read enable to register_block.
- o_r_addr  output  WORD_WIDTH  read address to register_block.
- i_r_value  input  WORD_WIDTH*VALUE_WORDS  read data from register_block.
- o_tx  output  1  UART serial out, idle high.
- o_busy  output  1  high from request accept until frame complete.
- o_done  output  1  one-cycle pulse when the frame completes.

Behaviour:
- Reset (i_reset=0, async): o_tx=1, o_ready=1, o_busy=0, o_r_en=0, o_r_addr=0, o_done=0, FSM=IDLE, all counters and shift registers cleared. Reset mid-frame aborts immediately. o_tx returns high with no partial-bit glitch-low.
- States:
  - IDLE -> READ when i_req=1.
  - READ -> LOAD after READ_LATENCY cycles.
  - LOAD -> SEND (one cycle).
  - SEND -> IDLE after the last stop bit.
- Accept cycle T (i_req=1 in IDLE):
  - Cycle T+1: o_r_en=1, o_r_addr=i_addr latched at T, o_ready=0, o_busy=1.
  - o_r_addr holds its value until the next accept.
- i_r_value is captured into the value register exactly READ_LATENCY cycles after the o_r_en cycle.
- LOAD builds the byte sequence: RESP_CODE, latched address, value[top byte] ... value[byte 0].
  - Total bytes N = 2+VALUE_WORDS.
- SEND, per byte:
  - Start bit (0), then WORD_WIDTH data bits LSB-first, then stop bit (1).
  - Each bit is held exactly DIVISOR clk cycles.
  - Bytes are back-to-back: the next start bit begins the cycle after the previous stop bit ends.
- Frame length is exactly N*(WORD_WIDTH+2)*DIVISOR cycles of SEND. Default: 6*10*8 = 480.
- o_done pulses for one cycle on the first IDLE cycle after the frame. o_busy falls and o_ready rises in that same cycle.
- Accept-to-done latency = 1 (o_r_en) + READ_LATENCY + 1 (LOAD) + frame length. Default: 483 cycles.
- i_req while o_ready=0 is ignored: no queueing, no effect on the current frame.
- i_req held high continuously: a new request is accepted on each IDLE cycle, so frames run back-to-back with one IDLE cycle between them.
- Address wrap: any WORD_WIDTH value is legal; 'hFF is transmitted as 'hFF.
- i_r_value changing after capture does not affect the frame in flight.

Test Plan:
- Reset mid-frame: assert i_reset=0 during byte 3 → o_tx=1 and o_busy=0 immediately. After release, a new request produces a complete, correct frame.
- Basic read: preload addr 'h12 = 'hbbb00b00, pulse i_req with i_addr='h12.
  - o_r_en is high for exactly one cycle with o_r_addr='h12.
  - The UART monitor decodes bytes 81 12 bb b0 0b 00.
  - o_done arrives 483 cycles after accept.
- Bit timing: for the byte 'h81, the start bit is low 8 cycles, then data bits 1,0,0,0,0,0,0,1 at 8 cycles each, then the stop bit is high 8 cycles. Every edge lands exactly on a DIVISOR boundary.
- Busy drop: a second i_req (addr 'h34) issued mid-frame → exactly one frame (addr 'h12) is sent, and no o_r_en is issued for 'h34.
- Sweep: write 'h00000000+addr to all 256 addresses, then read each → 256 frames, each decodes to the correct address/value pair. Run with READ_LATENCY=1 and again with READ_LATENCY=3.
- Back-to-back: hold i_req=1 for two frames → the second frame's start bit begins 2+READ_LATENCY+1 cycles after the first frame's o_done cycle, and no o_tx glitch occurs between frames.
